ofdm_cp_inserter: RTL and testbench

Transmit-side OFDM symbol framer: buffers one symbol of `nfft` frequency-to-time samples, then emits a cyclic prefix of `ng` samples (the last `ng` buffered samples) followed by the full `nfft`-sample body. It repeats this for `nsym` symbols per `go`. It sits between the IFFT output and the DAC/up-conversion path and produces the CP-then-body framing that the receiver's timing-offset counters expect.

---
 rtl/ofdm_pkg.sv | 25 ++
 rtl/ofdm_cp_inserter_sym_buf_ram.sv | 35 +++
 rtl/ofdm_cp_inserter.sv | 244 ++++++++++++++++++++++++
 tb/tb_ofdm_cp_inserter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// Shared types and limits for the OFDM cyclic-prefix framer.
package ofdm_pkg;

   localparam int OFDM_CNT_W = 12;

   // Largest symbol body the buffer can hold, and the smallest usable one.
   localparam logic [OFDM_CNT_W-1:0] CFG_NFFT_MAX = 12'd4095;
   localparam logic [OFDM_CNT_W-1:0] CFG_NFFT_MIN = 12'd2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_CP   = 3'd2,
      ST_BODY = 3'd3,
      ST_FIN  = 3'd4
   } cp_state_t;

   // A configuration is unusable when the body is too short or too long for
   // the buffer, or when the prefix would reach before the start of the body.
   function automatic logic cfg_bad(input logic [OFDM_CNT_W-1:0] nfft_v,
                                    input logic [OFDM_CNT_W-1:0] ng_v);
      cfg_bad = (nfft_v < CFG_NFFT_MIN) || (ng_v > nfft_v) || (nfft_v > CFG_NFFT_MAX);
   endfunction

endpackage

// File: rtl/ofdm_cp_inserter_sym_buf_ram.sv
// One-symbol sample buffer: one write port, one synchronous read port whose
// read register doubles as the framer's output data register.
module sym_buf_ram #(
   parameter int DW = 32,
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem_r [0:(1<<AW)-1];

   // Sample storage; contents are not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Read register holds its value until the next read is issued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data <= {DW{1'b0}};
      end else if (rd_en) begin
         rd_data <= mem_r[rd_addr];
      end
   end

endmodule

// File: rtl/ofdm_cp_inserter.sv
// Transmit OFDM framer: buffers one symbol, then emits its cyclic prefix
// (tail of the symbol) followed by the full body, nsym times per go.
module ofdm_cp_inserter
   import ofdm_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  go,
   input  logic [OFDM_CNT_W-1:0] nfft,
   input  logic [OFDM_CNT_W-1:0] ng,
   input  logic [OFDM_CNT_W-1:0] nsym,
   input  logic                  in_valid,
   input  logic [DW-1:0]         in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DW-1:0]         out_data,
   input  logic                  out_ready,
   output logic                  out_cp,
   output logic                  out_sos,
   output logic                  out_last,
   output logic                  sym_inc,
   output logic [OFDM_CNT_W-1:0] sym_cnt,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err
);

   cp_state_t state_r, state_n;

   logic [OFDM_CNT_W-1:0] nfft_r, ng_r, nsym_r, cp_start_r;
   logic [OFDM_CNT_W-1:0] wcnt_r, rcnt_r, sym_cnt_r;
   logic                  err_r;

   logic latch_s, wr_en_s, rd_en_s, adv_s, fin_done_s;
   logic load_last_s, rd_last_s, more_sym_s;
   logic sos_s, eos_s, frame_last_s;

   logic out_valid_r, out_cp_r, out_sos_r, out_last_r, out_eos_r;
   logic sym_inc_r, done_r, cfg_err_r, in_ready_r, busy_r;
   logic accept_eos_s;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Next-state decode and per-cycle control strobes.
   always_comb begin
      state_n      = state_r;
      latch_s      = 1'b0;
      wr_en_s      = 1'b0;
      rd_en_s      = 1'b0;
      adv_s        = 1'b0;
      fin_done_s   = 1'b0;
      sos_s        = 1'b0;
      eos_s        = 1'b0;
      frame_last_s = 1'b0;
      load_last_s  = (wcnt_r == (nfft_r - 12'd1));
      rd_last_s    = (rcnt_r == (nfft_r - 12'd1));
      more_sym_s   = ((sym_cnt_r + 12'd1) < nsym_r);
      case (state_r)
         ST_IDLE: begin
            if (go) begin
               latch_s = 1'b1;
               if (cfg_bad(nfft, ng)) begin
                  state_n = ST_FIN;
               end else if (nsym == 12'd0) begin
                  state_n = ST_FIN;
               end else begin
                  state_n = ST_LOAD;
               end
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_LOAD: begin
            wr_en_s = in_valid && in_ready_r;
            if (wr_en_s && load_last_s) begin
               if (ng_r == 12'd0) begin
                  state_n = ST_BODY;
               end else begin
                  state_n = ST_CP;
               end
            end else begin
               state_n = ST_LOAD;
            end
         end
         ST_CP: begin
            adv_s   = !out_valid_r || out_ready;
            rd_en_s = adv_s;
            sos_s   = (rcnt_r == cp_start_r);
            if (adv_s && rd_last_s) begin
               state_n = ST_BODY;
            end else begin
               state_n = ST_CP;
            end
         end
         ST_BODY: begin
            adv_s        = !out_valid_r || out_ready;
            rd_en_s      = adv_s;
            sos_s        = (rcnt_r == 12'd0) && (ng_r == 12'd0);
            eos_s        = rd_last_s;
            frame_last_s = rd_last_s && !more_sym_s;
            if (adv_s && rd_last_s) begin
               if (more_sym_s) begin
                  state_n = ST_LOAD;
               end else begin
                  state_n = ST_FIN;
               end
            end else begin
               state_n = ST_BODY;
            end
         end
         ST_FIN: begin
            fin_done_s = !out_valid_r || out_ready;
            if (fin_done_s) begin
               state_n = ST_IDLE;
            end else begin
               state_n = ST_FIN;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // Configuration captured on an accepted go; prefix start computed once here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nfft_r     <= 12'd0;
         ng_r       <= 12'd0;
         nsym_r     <= 12'd0;
         cp_start_r <= 12'd0;
         err_r      <= 1'b0;
      end else if (latch_s) begin
         nfft_r     <= nfft;
         ng_r       <= ng;
         nsym_r     <= nsym;
         cp_start_r <= nfft - ng;
         err_r      <= cfg_bad(nfft, ng);
      end
   end

   // Buffer write and read address counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wcnt_r <= 12'd0;
         rcnt_r <= 12'd0;
      end else begin
         if (latch_s) begin
            wcnt_r <= 12'd0;
         end else if (wr_en_s) begin
            wcnt_r <= load_last_s ? 12'd0 : (wcnt_r + 12'd1);
         end
         if (wr_en_s && load_last_s) begin
            rcnt_r <= (ng_r == 12'd0) ? 12'd0 : cp_start_r;
         end else if (rd_en_s) begin
            rcnt_r <= rd_last_s ? 12'd0 : (rcnt_r + 12'd1);
         end
      end
   end

   // Output valid and sideband flags travel with the registered read data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         out_cp_r    <= 1'b0;
         out_sos_r   <= 1'b0;
         out_last_r  <= 1'b0;
         out_eos_r   <= 1'b0;
      end else if (rd_en_s) begin
         out_valid_r <= 1'b1;
         out_cp_r    <= (state_r == ST_CP);
         out_sos_r   <= sos_s;
         out_last_r  <= frame_last_s;
         out_eos_r   <= eos_s;
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
         out_cp_r    <= 1'b0;
         out_sos_r   <= 1'b0;
         out_last_r  <= 1'b0;
         out_eos_r   <= 1'b0;
      end
   end

   assign accept_eos_s = out_valid_r && out_ready && out_eos_r;

   // Symbol accounting, frame-end pulses and state-derived status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sym_cnt_r  <= 12'd0;
         sym_inc_r  <= 1'b0;
         done_r     <= 1'b0;
         cfg_err_r  <= 1'b0;
         in_ready_r <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         if (latch_s) begin
            sym_cnt_r <= 12'd0;
         end else if (accept_eos_s) begin
            sym_cnt_r <= sym_cnt_r + 12'd1;
         end
         sym_inc_r  <= accept_eos_s;
         done_r     <= fin_done_s;
         cfg_err_r  <= fin_done_s && err_r;
         in_ready_r <= (state_n == ST_LOAD);
         busy_r     <= (state_n != ST_IDLE);
      end
   end

   sym_buf_ram #(
      .DW (DW),
      .AW (AW)
   ) u_sym_buf_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en_s),
      .wr_addr (wcnt_r[AW-1:0]),
      .wr_data (in_data),
      .rd_en   (rd_en_s),
      .rd_addr (rcnt_r[AW-1:0]),
      .rd_data (out_data)
   );

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_cp    = out_cp_r;
   assign out_sos   = out_sos_r;
   assign out_last  = out_last_r;
   assign sym_inc   = sym_inc_r;
   assign sym_cnt   = sym_cnt_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Self-checking bench for ofdm_cp_inserter: directed and randomized frames
// compared against a sample-sequence reference model.
module tb_ofdm_cp_inserter;

   localparam int DW = 32;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          reset, go;
   logic [11:0]   nfft, ng, nsym;
   logic          in_valid, in_ready;
   logic [DW-1:0] in_data, out_data;
   logic          out_valid, out_ready, out_cp, out_sos, out_last, sym_inc;
   logic [11:0]   sym_cnt;
   logic          busy, done, cfg_err;

   always #5 clk = ~clk;

   ofdm_cp_inserter #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .reset(reset), .go(go), .nfft(nfft), .ng(ng), .nsym(nsym),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .out_cp(out_cp), .out_sos(out_sos), .out_last(out_last),
      .sym_inc(sym_inc), .sym_cnt(sym_cnt), .busy(busy), .done(done),
      .cfg_err(cfg_err)
   );

   typedef struct packed {
      logic [DW-1:0] d;
      logic          cp;
      logic          sos;
      logic          last;
   } smp_t;

   // Monitor-owned records
   smp_t          acc_q[$];
   int            cyc = 0, sym_inc_cnt = 0, done_cnt = 0, err_cnt = 0, err_alone = 0;
   int            inrdy_cnt = 0, ov_cnt = 0, stall_bad = 0, done_cyc = 0, last_cyc = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;

   // Stimulus-owned records
   logic [DW-1:0] stim_q[$];
   int            n_cmp = 0, n_bad = 0;
   int            a0, d0, s0, e0, r0, v0;

   // Output monitor, sampling on the falling edge.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall && !(out_valid === 1'b1 && out_data === prev_data))
            stall_bad <= stall_bad + 1;
         prev_stall <= out_valid && !out_ready;
         prev_data  <= out_data;
         if (out_valid && out_ready) begin
            acc_q.push_back(smp_t'({out_data, out_cp, out_sos, out_last}));
            if (out_last) last_cyc <= cyc;
         end
         if (sym_inc) sym_inc_cnt <= sym_inc_cnt + 1;
         if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
         if (cfg_err) err_cnt <= err_cnt + 1;
         if (cfg_err && !done) err_alone <= err_alone + 1;
         if (in_ready) inrdy_cnt <= inrdy_cnt + 1;
         if (out_valid) ov_cnt <= ov_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      a0 = acc_q.size(); d0 = done_cnt; s0 = sym_inc_cnt;
      e0 = err_cnt; r0 = inrdy_cnt; v0 = ov_cnt;
   endtask

   // Drives one frame: go, sample feed (optionally random gaps and backpressure),
   // then waits for done. With abort set, reset is asserted in symbol 2's body.
   task automatic run_frame(input int f_nfft, input int f_ng, input int f_nsym,
                            input bit rnd, input bit abort);
      int idx = 0;
      int total;
      bit fin = 1'b0;
      bit bad;
      bad   = (f_nfft < 2) || (f_ng > f_nfft);
      total = (bad || f_nsym == 0) ? 0 : f_nfft * f_nsym;
      @(posedge clk); #1;
      go = 1'b1; nfft = 12'(f_nfft); ng = 12'(f_ng); nsym = 12'(f_nsym);
      out_ready = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      go = 1'b0; nfft = 12'($urandom); ng = 12'($urandom); nsym = 12'($urandom);
      if (total > 0) chk("go_to_load_in_ready", 32'(in_ready), 32'd1);
      for (int c = 0; c < 4000 && !fin; c++) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (idx < total) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = stim_q[idx];
         end else begin
            in_valid = 1'b0;
            in_data  = $urandom;
         end
         go = rnd && (idx < total) && ($urandom_range(0, 7) == 0);
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         if (done) fin = 1'b1;
         if (abort && (sym_inc_cnt - s0) >= 1 && out_valid && !out_cp && busy) begin
            #2 reset = 1'b1;
            #1;
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_sym_cnt", 32'(sym_cnt), 32'd0);
            chk("rst_out_data", out_data, 32'd0);
            chk("rst_out_last", 32'(out_last), 32'd0);
            fin = 1'b1;
         end
         @(posedge clk); #1;
      end
      go = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk("frame_completes", 32'(fin), 32'd1);
      if (abort) begin
         repeat (2) @(posedge clk);
         #1 reset = 1'b0;
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Reference model: for each symbol, the last ng samples then all nfft.
   task automatic check_frame(input int f_nfft, input int f_ng, input int f_nsym);
      smp_t exp_q[$];
      bit   bad;
      int   nexp, got;
      bad  = (f_nfft < 2) || (f_ng > f_nfft);
      nexp = bad ? 0 : f_nsym;
      for (int s = 0; s < nexp; s++) begin
         for (int i = 0; i < f_ng; i++)
            exp_q.push_back(smp_t'({stim_q[s*f_nfft + f_nfft - f_ng + i], 1'b1, (i == 0), 1'b0}));
         for (int i = 0; i < f_nfft; i++)
            exp_q.push_back(smp_t'({stim_q[s*f_nfft + i], 1'b0, (f_ng == 0 && i == 0),
                                    (s == nexp - 1 && i == f_nfft - 1)}));
      end
      got = acc_q.size() - a0;
      chk("sample_count", 32'(got), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got; i++) begin
         chk($sformatf("data[%0d]", i), acc_q[a0+i].d, exp_q[i].d);
         chk($sformatf("cp[%0d]", i), 32'(acc_q[a0+i].cp), 32'(exp_q[i].cp));
         chk($sformatf("sos[%0d]", i), 32'(acc_q[a0+i].sos), 32'(exp_q[i].sos));
         chk($sformatf("last[%0d]", i), 32'(acc_q[a0+i].last), 32'(exp_q[i].last));
      end
      chk("sym_inc_count", 32'(sym_inc_cnt - s0), 32'(nexp));
      chk("done_count", 32'(done_cnt - d0), 32'd1);
      chk("cfg_err_count", 32'(err_cnt - e0), 32'(bad));
      chk("cfg_err_without_done", 32'(err_alone), 32'd0);
      chk("sym_cnt", 32'(sym_cnt), 32'(nexp));
      chk("stall_data_stable", 32'(stall_bad), 32'd0);
      if (nexp > 0) begin
         chk("done_after_last_accept", 32'(done_cyc - last_cyc), 32'd1);
      end else begin
         chk("no_in_ready", 32'(inrdy_cnt - r0), 32'd0);
         chk("no_output", 32'(ov_cnt - v0), 32'd0);
      end
   endtask

   initial begin
      reset = 1'b1; go = 1'b0; nfft = '0; ng = '0; nsym = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", 32'(in_ready), 32'd0);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_sym_cnt", 32'(sym_cnt), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_out_data", out_data, 32'd0);
      reset = 1'b0;

      // Basic frame: 8-sample body, 2-sample prefix.
      stim_q.delete();
      for (int i = 0; i < 8; i++) stim_q.push_back(DW'(i));
      snap(); run_frame(8, 2, 1, 1'b0, 1'b0); check_frame(8, 2, 1);

      // No prefix.
      snap(); run_frame(8, 0, 1, 1'b0, 1'b0); check_frame(8, 0, 1);

      // Three symbols in one frame.
      stim_q.delete();
      for (int s = 1; s <= 3; s++)
         for (int i = 0; i < 4; i++) stim_q.push_back(DW'(s * 10 + i));
      snap(); run_frame(4, 1, 3, 1'b0, 1'b0); check_frame(4, 1, 3);

      // Random data, input gaps, backpressure and stray go pulses.
      stim_q.delete();
      for (int i = 0; i < 48; i++) stim_q.push_back($urandom);
      snap(); run_frame(16, 4, 3, 1'b1, 1'b0); check_frame(16, 4, 3);

      // Prefix equal to body length, random handshakes.
      stim_q.delete();
      for (int i = 0; i < 10; i++) stim_q.push_back($urandom);
      snap(); run_frame(5, 5, 2, 1'b1, 1'b0); check_frame(5, 5, 2);

      // Rejected configurations and an empty frame.
      stim_q.delete();
      snap(); run_frame(8, 9, 1, 1'b0, 1'b0); check_frame(8, 9, 1);
      snap(); run_frame(1, 0, 1, 1'b0, 1'b0); check_frame(1, 0, 1);
      snap(); run_frame(8, 2, 0, 1'b0, 1'b0); check_frame(8, 2, 0);

      // Reset during the body of symbol 2 of 3.
      for (int i = 0; i < 24; i++) stim_q.push_back($urandom);
      snap(); run_frame(8, 2, 3, 1'b0, 1'b1);
      chk("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
      chk("idle_after_reset", 32'(busy), 32'd0);

      // A clean frame after the reset.
      stim_q.delete();
      for (int i = 0; i < 8; i++) stim_q.push_back($urandom);
      snap(); run_frame(8, 2, 1, 1'b1, 1'b0); check_frame(8, 2, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
